// File: rtl/fft_frame_buffer.sv
// Ping-pong spectrum frame buffer: captures FRAME_LEN-word frames into one bank
// while the other bank holds the latest complete frame for upload on request.
//   state   | meaning
//   IDLE    | waiting for upload_start; frame swaps allowed
//   READ    | streaming the held frame, one address per cycle
module fft_frame_buffer #(
  parameter int DATA_W    = 64,
  parameter int FRAME_LEN = 512,
  parameter int ADDR_W    = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid_i,
  input  logic              frame_start_i,
  input  logic              upload_start,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid_o,
  output logic              frame_ready,
  output logic              reading,
  output logic [15:0]       drop_cnt,
  output logic              underrun
);

  localparam logic [0:0]        ST_IDLE   = 1'b0;
  localparam logic [0:0]        ST_READ   = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  logic [DATA_W-1:0] mem_q [2*FRAME_LEN];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic              synced_q, synced_d;
  logic              wr_bank_q, wr_bank_d;
  logic              frame_ready_q, frame_ready_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              underrun_q, underrun_d;
  logic [DATA_W-1:0] data_out_q;
  logic              data_valid_q;

  logic              wr_fire;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_last;
  logic              swap;

  assign wr_fire = en & data_valid_i & (frame_start_i | synced_q);
  assign wr_addr = frame_start_i ? '0 : wr_cnt_q;
  assign wr_last = wr_fire & (wr_addr == LAST_ADDR);
  assign swap    = wr_last & (state_q == ST_IDLE);

  always_comb begin
    state_d       = state_q;
    rd_addr_d     = rd_addr_q;
    wr_cnt_d      = wr_cnt_q;
    synced_d      = synced_q;
    wr_bank_d     = wr_bank_q;
    frame_ready_d = frame_ready_q;
    drop_cnt_d    = drop_cnt_q;
    underrun_d    = underrun_q;
    if (!en) begin
      state_d       = ST_IDLE;
      frame_ready_d = 1'b0;
      synced_d      = 1'b0;
      wr_cnt_d      = '0;
    end else begin
      if (wr_fire) begin
        if (wr_last) begin
          synced_d = 1'b0;
          wr_cnt_d = '0;
        end else begin
          synced_d = 1'b1;
          wr_cnt_d = wr_addr + ADDR_W'(1);
        end
      end
      // A frame finishing while the reader is busy cannot swap banks, so it is lost
      if (wr_last) begin
        if (state_q == ST_IDLE) begin
          wr_bank_d     = ~wr_bank_q;
          frame_ready_d = 1'b1;
        end else if (drop_cnt_q != 16'hFFFF) begin
          drop_cnt_d = drop_cnt_q + 16'd1;
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (upload_start) begin
            if (frame_ready_q | swap) begin
              state_d       = ST_READ;
              rd_addr_d     = '0;
              frame_ready_d = 1'b0;
            end else begin
              underrun_d = 1'b1;
            end
          end
        end
        ST_READ: begin
          if (rd_addr_q == LAST_ADDR) state_d = ST_IDLE;
          else                        rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[{wr_bank_q, wr_addr}] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rd_addr_q     <= '0;
      wr_cnt_q      <= '0;
      synced_q      <= 1'b0;
      wr_bank_q     <= 1'b0;
      frame_ready_q <= 1'b0;
      drop_cnt_q    <= '0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_addr_q     <= rd_addr_d;
      wr_cnt_q      <= wr_cnt_d;
      synced_q      <= synced_d;
      wr_bank_q     <= wr_bank_d;
      frame_ready_q <= frame_ready_d;
      drop_cnt_q    <= drop_cnt_d;
      underrun_q    <= underrun_d;
    end
  end

  // data_out keeps its last word whenever nothing is being streamed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else if (!en) begin
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= (state_q == ST_READ);
      if (state_q == ST_READ) data_out_q <= mem_q[{~wr_bank_q, rd_addr_q}];
    end
  end

  assign data_out     = data_out_q;
  assign data_valid_o = data_valid_q;
  assign frame_ready  = frame_ready_q;
  assign reading      = (state_q == ST_READ);
  assign drop_cnt     = drop_cnt_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Directed bench for fft_frame_buffer: table of capture/upload vectors plus
// hand-written sequences for drop, underrun, unsynced start, flush and reset.
module tb_fft_frame_buffer;

  localparam int N = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic [63:0] data_in = '0;
  logic        data_valid_i = 1'b0;
  logic        frame_start_i = 1'b0;
  logic        upload_start = 1'b0;
  logic [63:0] data_out;
  logic        data_valid_o;
  logic        frame_ready;
  logic        reading;
  logic [15:0] drop_cnt;
  logic        underrun;

  int checks = 0;
  int failures = 0;

  fft_frame_buffer #(.DATA_W(64), .FRAME_LEN(N), .ADDR_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .data_in(data_in), .data_valid_i(data_valid_i), .frame_start_i(frame_start_i),
    .upload_start(upload_start),
    .data_out(data_out), .data_valid_o(data_valid_o), .frame_ready(frame_ready),
    .reading(reading), .drop_cnt(drop_cnt), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          pre_len;
    bit          pre_fs;
    int          n_frames;
    logic [63:0] base_a;
    logic [63:0] base_b;
    logic [63:0] exp_base;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_words(input logic [63:0] base, input int n, input int fs_idx);
    for (int i = 0; i < n; i++) begin
      data_in       = base + 64'(i);
      data_valid_i  = 1'b1;
      frame_start_i = (i == fs_idx);
      tick();
    end
    data_valid_i  = 1'b0;
    frame_start_i = 1'b0;
  endtask

  task automatic verify_upload(input string name, input logic [63:0] exp_base);
    int errs;
    upload_start = 1'b1;
    tick();
    upload_start = 1'b0;
    chk({name, "_reading_T1"}, 64'(reading), 64'd1);
    chk({name, "_valid_T1"}, 64'(data_valid_o), 64'd0);
    errs = 0;
    for (int i = 0; i < N; i++) begin
      tick();
      if (data_valid_o !== 1'b1 || data_out !== exp_base + 64'(i)) begin
        if (errs == 0)
          $display("first bad word %0d: valid=%b data=%h", i, data_valid_o, data_out);
        errs++;
      end
    end
    chk({name, "_bad_words"}, 64'(errs), 64'd0);
    chk({name, "_reading_end"}, 64'(reading), 64'd0);
    tick();
    chk({name, "_valid_after"}, 64'(data_valid_o), 64'd0);
    chk({name, "_ready_after"}, 64'(frame_ready), 64'd0);
  endtask

  initial begin
    int errs;

    vecs[0] = '{pre_len: 0,   pre_fs: 1'b0, n_frames: 1, base_a: 64'h0,
                base_b: 64'h0, exp_base: 64'h0};
    vecs[1] = '{pre_len: 0,   pre_fs: 1'b0, n_frames: 2, base_a: 64'h100,
                base_b: 64'h200, exp_base: 64'h200};
    vecs[2] = '{pre_len: 37,  pre_fs: 1'b1, n_frames: 1, base_a: 64'hCAFE_0000,
                base_b: 64'h0, exp_base: 64'hCAFE_0000};
    vecs[3] = '{pre_len: 100, pre_fs: 1'b0, n_frames: 1, base_a: 64'h5A5A_0000_0000_0000,
                base_b: 64'h0, exp_base: 64'h5A5A_0000_0000_0000};

    #22;
    chk("rst_data_out", data_out, 64'h0);
    chk("rst_valid", 64'(data_valid_o), 64'd0);
    chk("rst_ready", 64'(frame_ready), 64'd0);
    chk("rst_reading", 64'(reading), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 4; k++) begin
      if (vecs[k].pre_len > 0)
        send_words(64'hBAD0, vecs[k].pre_len, vecs[k].pre_fs ? 0 : -1);
      send_words(vecs[k].base_a, N, 0);
      if (vecs[k].n_frames > 1) send_words(vecs[k].base_b, N, 0);
      chk($sformatf("v%0d_ready", k), 64'(frame_ready), 64'd1);
      verify_upload($sformatf("v%0d", k), vecs[k].exp_base);
      chk($sformatf("v%0d_drop", k), 64'(drop_cnt), 64'd0);
    end

    // Frame B completes while A is streaming: A stays intact, B is dropped
    send_words(64'h3300, N, 0);
    fork
      verify_upload("drop", 64'h3300);
      send_words(64'h3400, N, 0);
    join
    chk("drop_cnt", 64'(drop_cnt), 64'd1);
    chk("drop_underrun_pre", 64'(underrun), 64'd0);
    upload_start = 1'b1;
    tick();
    upload_start = 1'b0;
    chk("underrun_set", 64'(underrun), 64'd1);
    chk("underrun_reading", 64'(reading), 64'd0);
    errs = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (data_valid_o !== 1'b0 || reading !== 1'b0) errs++;
    end
    chk("underrun_no_output", 64'(errs), 64'd0);

    // Flush at the 200th output word
    send_words(64'h4000, N, 0);
    chk("flush_ready_pre", 64'(frame_ready), 64'd1);
    upload_start = 1'b1;
    tick();
    upload_start = 1'b0;
    repeat (200) tick();
    chk("flush_word199", data_out, 64'h4000 + 64'd199);
    chk("flush_word199_valid", 64'(data_valid_o), 64'd1);
    en = 1'b0;
    tick();
    chk("flush_valid", 64'(data_valid_o), 64'd0);
    chk("flush_reading", 64'(reading), 64'd0);
    chk("flush_ready", 64'(frame_ready), 64'd0);
    chk("flush_data_hold", data_out, 64'h4000 + 64'd199);
    en = 1'b1;
    tick();
    send_words(64'h6000, N, 0);
    chk("flush2_ready_pre", 64'(frame_ready), 64'd1);
    en = 1'b0;
    tick();
    chk("flush2_ready_cleared", 64'(frame_ready), 64'd0);
    en = 1'b1;
    tick();
    send_words(64'h6100, N, 0);
    chk("reenable_ready", 64'(frame_ready), 64'd1);
    verify_upload("reenable", 64'h6100);
    chk("reenable_drop_held", 64'(drop_cnt), 64'd1);

    // Asynchronous reset in the middle of a frame write
    for (int i = 0; i < 50; i++) begin
      data_in       = 64'h8000 + 64'(i);
      data_valid_i  = 1'b1;
      frame_start_i = (i == 0);
      tick();
    end
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_data_out", data_out, 64'h0);
    chk("arst_valid", 64'(data_valid_o), 64'd0);
    chk("arst_ready", 64'(frame_ready), 64'd0);
    chk("arst_reading", 64'(reading), 64'd0);
    chk("arst_drop", 64'(drop_cnt), 64'd0);
    chk("arst_underrun", 64'(underrun), 64'd0);
    data_valid_i  = 1'b0;
    frame_start_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Unsynced after reset: junk ignored until the first frame_start_i
    send_words(64'hAAAA, 100, -1);
    chk("unsync_ready_junk", 64'(frame_ready), 64'd0);
    send_words(64'h7000, 300 + N, 300);
    chk("unsync_ready", 64'(frame_ready), 64'd1);
    verify_upload("unsync", 64'h7000 + 64'd300);
    chk("unsync_drop", 64'(drop_cnt), 64'd0);
    chk("unsync_underrun", 64'(underrun), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
